// File: rtl/spi_shift_engine.sv
// SPI master shift engine: serializes one DW-bit word on mosi and captures DW bits
// from miso, paced by the sampling/update strobes of an upstream rate generator.
module spi_shift_engine #(
    parameter int DW        = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DW-1:0]             tx_data,
    output logic [DW-1:0]             rx_data,
    output logic                      busy,
    output logic                      done,
    output logic                      rate_en,
    input  logic                      clk_out,
    input  logic                      sampling,
    input  logic                      update,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      cs_n,
    output logic [1:0]                dbg_state,
    output logic [$clog2(DW+1)-1:0]   dbg_bit_cnt
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_tx_sh;
    logic [DW-1:0] r_rx_sh;
    logic [DW-1:0] r_rx_data;
    logic [CW-1:0] r_bit_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_rate_en;
    logic          r_mosi;
    logic          r_cs_n;

    logic          w_accept;
    logic          w_sample;
    logic          w_shift;
    logic          w_finish;
    logic          w_first_bit;
    logic          w_next_bit;
    logic [DW-1:0] w_tx_shifted;
    logic [DW-1:0] w_rx_shifted;

    // All strobe decisions use the pre-edge bit count. Sampling is refused once
    // DW bits are in, so a strobe coinciding with the trailing update cannot
    // push a stray bit into the receive shifter.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_sample = (r_state == S_XFER) && sampling && (r_bit_cnt < CW'(DW));
    assign w_shift  = (r_state == S_XFER) && update && (r_bit_cnt != '0)
                      && (r_bit_cnt < CW'(DW));
    assign w_finish = (r_state == S_XFER) && update && (r_bit_cnt == CW'(DW));

    assign w_first_bit  = LSB_FIRST ? tx_data[0] : tx_data[DW-1];
    assign w_next_bit   = LSB_FIRST ? r_tx_sh[1] : r_tx_sh[DW-2];
    assign w_tx_shifted = LSB_FIRST ? (r_tx_sh >> 1) : (r_tx_sh << 1);
    assign w_rx_shifted = LSB_FIRST ? {miso, r_rx_sh[DW-1:1]}
                                    : {r_rx_sh[DW-2:0], miso};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)    w_next = S_XFER;
            S_XFER:  if (w_finish) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rate_en <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_busy    <= (w_next != S_IDLE);
            r_rate_en <= (w_next == S_XFER);
            r_cs_n    <= (w_next != S_XFER);
            r_done    <= (w_next == S_DONE);
            if (w_accept) begin
                r_tx_sh   <= tx_data;
                r_mosi    <= w_first_bit;
                r_bit_cnt <= '0;
            end
            if (w_sample) begin
                r_rx_sh   <= w_rx_shifted;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if (w_shift) begin
                r_tx_sh <= w_tx_shifted;
                r_mosi  <= w_next_bit;
            end
            if (w_finish) begin
                r_rx_data <= r_rx_sh;
                r_mosi    <= 1'b0;
            end
        end
    end

    assign sclk        = (r_state == S_XFER) & clk_out;
    assign rx_data     = r_rx_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign rate_en     = r_rate_en;
    assign mosi        = r_mosi;
    assign cs_n        = r_cs_n;
    assign dbg_state   = r_state;
    assign dbg_bit_cnt = r_bit_cnt;

endmodule
